mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_access_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - control-unit and RAM signal bundle for mem_access_ctrl
interface mem_access_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic        load_half;
    logic        save_half;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_ok;
    logic        mem_err;
    logic        ram_req;
    logic        ram_we;
    logic [29:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    modport slave (
        input  mem_read, mem_write, load_half, save_half, addr, wdata,
        input  ram_rdata, ram_ack,
        output rdata, mem_ok, mem_err,
        output ram_req, ram_we, ram_addr, ram_be, ram_wdata
    );

    modport master (
        output mem_read, mem_write, load_half, save_half, addr, wdata,
        output ram_rdata, ram_ack,
        input  rdata, mem_ok, mem_err,
        input  ram_req, ram_we, ram_addr, ram_be, ram_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-access RAM controller with halfword support and ack timeout
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    mem_access_ctrl_if.slave bus
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] rdata_q;
    logic        ok_q;
    logic        err_q;
    logic        req_q;
    logic        we_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        half_q;
    logic        hi_q;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_half = hi_q ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        ld_data = half_q ? {{16{ld_half[15]}}, ld_half} : bus.ram_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            half_q  <= 1'b0;
            hi_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // write wins when both strobes arrive together
                    if (bus.mem_write || bus.mem_read) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        we_q    <= bus.mem_write;
                        addr_q  <= bus.addr[31:2];
                        hi_q    <= bus.addr[1];
                        if (bus.mem_write) begin
                            half_q <= bus.save_half;
                            if (bus.save_half) begin
                                be_q    <= bus.addr[1] ? 4'b1100 : 4'b0011;
                                wdata_q <= {bus.wdata[15:0], bus.wdata[15:0]};
                            end else begin
                                be_q    <= 4'b1111;
                                wdata_q <= bus.wdata;
                            end
                        end else begin
                            half_q  <= bus.load_half;
                            be_q    <= 4'b1111;
                            wdata_q <= bus.wdata;
                        end
                    end
                end
                BUSY: begin
                    // an ack on the final counted cycle still counts as success
                    if (bus.ram_ack || cnt_q == CW'(TIMEOUT)) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        ok_q    <= 1'b1;
                        err_q   <= ~bus.ram_ack;
                        if (!we_q) begin
                            rdata_q <= bus.ram_ack ? ld_data : 32'h0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ok_q    <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.mem_ok    = ok_q;
    assign bus.mem_err   = err_q;
    assign bus.ram_req   = req_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_be    = be_q;
    assign bus.ram_wdata = wdata_q;
endmodule
